instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that reads the 128-entry, 9-bit instruction memory. It owns the program counter and drives the memory address port combinationally. It registers the returned instruction, together with its PC and a valid flag, for the decoder. It also handles program start/done handshaking, sequential increment, absolute and relative branch redirection, stall and halt.

Parameters:
ADDR_W, 7, program counter / memory address width
INSTR_W, 9, instruction width
NUM_INSTR, 128, number of valid instruction words; PC wraps modulo 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins execution at start_addr
start_addr  input  ADDR_W  first PC of program
stall  input  1  freeze PC and output registers this cycle
branch_en  input  1  redirect; qualifies the instruction currently on instr/instr_valid
branch_rel  input  1  1 = branch_target is a signed offset from instr_pc; 0 = absolute address
branch_target  input  ADDR_W  absolute address or two's-complement offset
halt  input  1  decoder flags the current valid instruction as halt
rom_address  output  ADDR_W  address to instruction memory (= PC)
rom_instruction  input  INSTR_W  combinational read data from instruction memory
instr  output  INSTR_W  registered instruction
instr_pc  output  ADDR_W  PC of instr
instr_valid  output  1  instr is on the correct path and must be executed
busy  output  1  high in RUN
done  output  1  high in HALTED until next start

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (asynchronous, takes effect immediately; any in-flight program is aborted) puts all outputs to these values:
  - state = IDLE, pc = 0, rom_address = 0
  - instr = 0, instr_pc = 0, instr_valid = 0
  - busy = 0, done = 0
- rom_address = pc at all times; the memory is combinational, so read data is used in the same cycle.
- IDLE:
  - start=1 -> pc <= start_addr, state <= RUN.
  - Other inputs are ignored.
- HALTED:
  - done=1.
  - start=1 -> pc <= start_addr, done <= 0, state <= RUN.
- RUN:
  - busy=1.
  - start is ignored.
  - Priority per cycle is halt > stall > branch > sequential. halt and branch_en count only when instr_valid=1.
- halt (with instr_valid=1):
  - state <= HALTED, instr_valid <= 0, done <= 1.
  - pc holds its value.
  - halt during stall still wins.
- stall=1 (no halt):
  - pc, instr, instr_pc and instr_valid all hold.
  - branch_en is ignored; the decoder must keep it asserted until stall drops.
- branch_en=1:
  - pc <= target.
    - Absolute: target = branch_target.
    - Relative: target = instr_pc + sign-extended branch_target, truncated to ADDR_W (wraps).
  - instr_valid <= 0 for exactly one cycle. This squashes the wrong-path word fetched this cycle.
- Sequential case:
  - instr <= rom_instruction, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc + 1, wrapping from 127 to 0.
- Latency: start at cycle t -> pc = start_addr at t+1 -> instr_valid=1 with instr_pc = start_addr at t+2.
- Branch penalty is one bubble: branch seen at cycle t -> instr_valid=0 at t+1 -> target instruction valid at t+2.
- Out-of-range PCs (pc >= NUM_INSTR) are still fetched; the memory returns 0 for them and they are not flagged.
- Simultaneous branch_en and halt: halt wins and the branch is dropped.

Decomposition:
- Shared package isa_pkg holds:
  - ADDR_W and INSTR_W constants
  - addr_t and instr_t typedefs
  - fetch_state_t enum {IDLE, RUN, HALTED}
- One natural combinational sub-module, pc_next_logic: inputs pc, instr_pc, branch_en, branch_rel, branch_target; output next_pc.
- Top level keeps the FSM and registers.

Test Plan:
- Memory preloaded with word[i] = i, start_addr = 5, start pulse at t -> instr_valid rises at t+2; instr/instr_pc read 5/5, 6/6, 7/7 on consecutive cycles; busy=1.
- Sequential fetch from start_addr = 126 -> instr_pc sequence 126, 127, 0, 1; no gap in instr_valid.
- Absolute branch_en when instr_pc = 10, branch_target = 40 -> one cycle instr_valid=0, then instr_pc = 40.
- Relative branch: instr_pc = 3, branch_target = 7'b1111110 (-2) -> bubble, then instr_pc = 1. Also instr_pc = 126, offset +5 -> instr_pc = 3.
- stall held 3 cycles at instr_pc = 20 -> instr, instr_pc and rom_address frozen; on release, instr_pc = 21 next cycle.
- halt with instr_valid at instr_pc = 12 (with branch_en also high) -> next cycle instr_valid=0, done=1, busy=0. A new start with start_addr = 0 clears done, and instr_pc = 0 is valid two cycles later. Asserting reset mid-RUN clears all outputs immediately.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : Shared widths, types and fetch FSM state encoding for the
//               instruction fetch slice.
// Contents    : ADDR_W, INSTR_W, NUM_INSTR constants; addr_t, instr_t
//               typedefs; fetch_state_t enum.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

  localparam int ADDR_W    = 7;
  localparam int INSTR_W   = 9;
  // Words physically present; PC still wraps modulo 2**ADDR_W.
  localparam int NUM_INSTR = 128;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Control, branch, memory and decoder-facing signals of the
//               fetch stage.
// Modports    : master - control/decoder/memory side (drives start, stall,
//                        branch, halt and rom_instruction)
//               slave  - fetch stage (drives rom_address, instr, instr_pc,
//                        instr_valid, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  import isa_pkg::*;

  logic   start;
  addr_t  start_addr;
  logic   stall;
  logic   branch_en;
  logic   branch_rel;
  addr_t  branch_target;
  logic   halt;
  addr_t  rom_address;
  instr_t rom_instruction;
  instr_t instr;
  addr_t  instr_pc;
  logic   instr_valid;
  logic   busy;
  logic   done;

  modport master (
    output start, start_addr, stall, branch_en, branch_rel, branch_target,
           halt, rom_instruction,
    input  rom_address, instr, instr_pc, instr_valid, busy, done
  );

  modport slave (
    input  start, start_addr, stall, branch_en, branch_rel, branch_target,
           halt, rom_instruction,
    output rom_address, instr, instr_pc, instr_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC selection: sequential increment or
//               branch target (absolute, or relative to the PC of the
//               instruction that issued the branch).
// Ports       : pc_i            - current fetch PC
//               instr_pc_i      - PC of the instruction on the decoder output
//               branch_en_i     - qualified branch request
//               branch_rel_i    - 1 = relative offset, 0 = absolute address
//               branch_target_i - absolute address or two's-complement offset
//               next_pc_o       - selected next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
  import isa_pkg::*;
(
  input  addr_t pc_i,
  input  addr_t instr_pc_i,
  input  logic  branch_en_i,
  input  logic  branch_rel_i,
  input  addr_t branch_target_i,
  output addr_t next_pc_o
);

  addr_t target_w;

  // The offset has the same width as the PC, so sign extension followed by
  // truncation to ADDR_W reduces to a plain modular add.
  always_comb begin
    target_w  = branch_rel_i ? addr_t'(instr_pc_i + branch_target_i)
                             : branch_target_i;
    next_pc_o = branch_en_i ? target_w : addr_t'(pc_i + addr_t'(1));
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Owns the PC, presents it to a combinational
//               instruction memory and registers the returned word with its
//               PC and a valid flag. Handles start/done, stall, branch and
//               halt.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - instruction_fetch_if.slave (control, memory, decoder)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import isa_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.slave  bus
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  instr_t       instr_q, instr_d;
  addr_t        instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;

  addr_t        next_pc_w;
  logic         branch_take_w;

  // Branches only count when they refer to a valid instruction.
  assign branch_take_w = bus.branch_en & valid_q;

  pc_next_logic u_pc_next (
    .pc_i            (pc_q),
    .instr_pc_i      (instr_pc_q),
    .branch_en_i     (branch_take_w),
    .branch_rel_i    (bus.branch_rel),
    .branch_target_i (bus.branch_target),
    .next_pc_o       (next_pc_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.halt && valid_q) begin
          // Halt beats stall and branch; PC is left where it was.
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          // Everything holds; a pending branch is re-presented later.
        end else if (branch_take_w) begin
          // Redirect and drop the wrong-path word fetched this cycle.
          pc_d    = next_pc_w;
          valid_d = 1'b0;
        end else begin
          instr_d    = bus.rom_instruction;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = next_pc_w;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.rom_address = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. Memory
//               holds word[i] = i; expected (instr_pc, instr) pairs are
//               queued when stimulus is applied and popped whenever the DUT
//               presents a valid instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
  import isa_pkg::*;

  typedef struct {
    addr_t  pc;
    instr_t ins;
  } exp_t;

  logic   clk;
  logic   reset;
  int     checks;
  int     errors;
  exp_t   sb[$];
  instr_t mem [NUM_INSTR];

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  assign ifc.rom_instruction = mem[ifc.rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int a);
    exp_t e;
    e.pc  = addr_t'(a);
    e.ins = instr_t'(a);
    return e;
  endfunction

  // Advance one clock, sample 1 time unit later, check valid and, when the
  // DUT presents a new instruction, compare it with the scoreboard head.
  task automatic tick(input logic exp_v, input bit do_pop, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(ifc.instr_valid), 32'(exp_v));
    if (do_pop && ifc.instr_valid === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_instr_pc"}, 32'(ifc.instr_pc), 32'(e.pc));
        chk({tag, "_instr"},    32'(ifc.instr),    32'(e.ins));
      end
    end
  endtask

  task automatic branch_to(input logic rel, input int tgt, input int exp_pc, input string tag);
    ifc.branch_en     = 1'b1;
    ifc.branch_rel    = rel;
    ifc.branch_target = addr_t'(tgt);
    sb.push_back(mk(exp_pc));
    tick(1'b0, 1'b0, {tag, "_bubble"});
    chk({tag, "_rom_addr"}, 32'(ifc.rom_address), 32'(exp_pc));
    ifc.branch_en = 1'b0;
    tick(1'b1, 1'b1, {tag, "_target"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NUM_INSTR; i++) mem[i] = instr_t'(i);

    reset             = 1'b1;
    ifc.start         = 1'b0;
    ifc.start_addr    = '0;
    ifc.stall         = 1'b0;
    ifc.branch_en     = 1'b0;
    ifc.branch_rel    = 1'b0;
    ifc.branch_target = '0;
    ifc.halt          = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",    32'(ifc.instr_valid), 32'd0);
    chk("rst_instr",    32'(ifc.instr),       32'd0);
    chk("rst_instr_pc", 32'(ifc.instr_pc),    32'd0);
    chk("rst_rom_addr", 32'(ifc.rom_address), 32'd0);
    chk("rst_busy",     32'(ifc.busy),        32'd0);
    chk("rst_done",     32'(ifc.done),        32'd0);
    reset = 1'b0;
    tick(1'b0, 1'b1, "idle");

    // Start at 5: valid two cycles after the start pulse
    ifc.start      = 1'b1;
    ifc.start_addr = addr_t'(5);
    for (int i = 5; i <= 7; i++) sb.push_back(mk(i));
    tick(1'b0, 1'b1, "start5_t1");
    chk("start5_rom_addr", 32'(ifc.rom_address), 32'd5);
    chk("start5_busy",     32'(ifc.busy),        32'd1);
    ifc.start = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, "seq5");
    chk("seq5_busy", 32'(ifc.busy), 32'd1);
    ifc.halt = 1'b1;
    tick(1'b0, 1'b1, "halt7");
    chk("halt7_done", 32'(ifc.done), 32'd1);
    ifc.halt = 1'b0;

    // Wrap-around from 126
    ifc.start      = 1'b1;
    ifc.start_addr = addr_t'(126);
    sb.push_back(mk(126));
    sb.push_back(mk(127));
    sb.push_back(mk(0));
    sb.push_back(mk(1));
    tick(1'b0, 1'b1, "start126");
    chk("start126_done", 32'(ifc.done), 32'd0);
    ifc.start = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, "wrap");

    // Absolute branch from instr_pc = 10 to 40 (sequence continues 2,3,...)
    for (int i = 2; i <= 10; i++) sb.push_back(mk(i));
    for (int i = 2; i <= 10; i++) tick(1'b1, 1'b1, "run_to10");
    branch_to(1'b0, 40, 40, "abs40");

    // Relative branches: 3 + (-2) = 1, and 126 + 5 wraps to 3
    branch_to(1'b0, 3, 3, "abs3");
    branch_to(1'b1, 7'b1111110, 1, "rel_m2");
    branch_to(1'b0, 126, 126, "abs126");
    branch_to(1'b1, 5, 3, "rel_p5");

    // Stall at instr_pc = 20 with a branch held that must be ignored
    branch_to(1'b0, 20, 20, "abs20");
    ifc.stall         = 1'b1;
    ifc.branch_en     = 1'b1;
    ifc.branch_rel    = 1'b0;
    ifc.branch_target = addr_t'(99);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, "stall");
      chk("stall_instr_pc", 32'(ifc.instr_pc),    32'd20);
      chk("stall_instr",    32'(ifc.instr),       32'd20);
      chk("stall_rom_addr", 32'(ifc.rom_address), 32'd21);
    end
    ifc.stall     = 1'b0;
    ifc.branch_en = 1'b0;
    sb.push_back(mk(21));
    tick(1'b1, 1'b1, "unstall");

    // Halt with a simultaneous branch at instr_pc = 12
    branch_to(1'b0, 12, 12, "abs12");
    ifc.halt          = 1'b1;
    ifc.branch_en     = 1'b1;
    ifc.branch_target = addr_t'(50);
    tick(1'b0, 1'b1, "halt12");
    chk("halt12_done",     32'(ifc.done),        32'd1);
    chk("halt12_busy",     32'(ifc.busy),        32'd0);
    chk("halt12_rom_addr", 32'(ifc.rom_address), 32'd13);
    ifc.halt      = 1'b0;
    ifc.branch_en = 1'b0;
    tick(1'b0, 1'b1, "halted");
    chk("halted_done", 32'(ifc.done), 32'd1);

    // Restart from HALTED at 0
    ifc.start      = 1'b1;
    ifc.start_addr = addr_t'(0);
    sb.push_back(mk(0));
    tick(1'b0, 1'b1, "start0");
    chk("start0_done", 32'(ifc.done), 32'd0);
    chk("start0_busy", 32'(ifc.busy), 32'd1);
    ifc.start = 1'b0;
    tick(1'b1, 1'b1, "start0_valid");

    // Asynchronous reset mid-run
    reset = 1'b1;
    #1;
    chk("arst_valid",    32'(ifc.instr_valid), 32'd0);
    chk("arst_instr",    32'(ifc.instr),       32'd0);
    chk("arst_instr_pc", 32'(ifc.instr_pc),    32'd0);
    chk("arst_rom_addr", 32'(ifc.rom_address), 32'd0);
    chk("arst_busy",     32'(ifc.busy),        32'd0);
    chk("arst_done",     32'(ifc.done),        32'd0);
    #2;
    reset = 1'b0;
    tick(1'b0, 1'b1, "post_rst");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
